seg7_mux_driver: RTL and testbench

Display-side encoder for the dice project's two-digit multiplexed 7-segment display. It takes the ones and tens BCD digits produced by the roller core and time-multiplexes them onto one shared segment bus with two common lines. Segment and common polarity are selectable at runtime, and a dead-time gap between digits prevents ghosting. New digit values are accepted through a load/ack handshake and applied only at frame boundaries, so a frame never shows a torn value.

---
 rtl/seg7_mux_driver.sv | 160 ++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed 7-segment driver: gap/show scan, runtime polarity,
// and a shadow-register handshake that swaps digits only at frame boundaries.
module seg7_mux_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       load,
    output logic       ack,
    input  logic       seg_active_high,
    input  logic       com_active_high,
    input  logic       blank_lz,
    output logic [7:0] seg,
    output logic [1:0] com,
    output logic [1:0] com_oe
);
    localparam int MAX_PHASE = (GAP_CYCLES > REFRESH_DIV) ? GAP_CYCLES : REFRESH_DIV;
    localparam int CW = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {GAP0, SHOW1, GAP1, SHOW10} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      shadow1_q, shadow1_d, shadow10_q, shadow10_d;
    logic [3:0]      disp1_q, disp1_d, disp10_q, disp10_d;
    logic            pending_q, pending_d;
    logic            ack_q, ack_d;
    logic [7:0]      seg_q, seg_d;
    logic [1:0]      com_q, com_d;
    logic [1:0]      com_oe_q, com_oe_d;

    logic            phase_last;
    logic            boundary;
    logic [6:0]      lit;
    logic [1:0]      com_lit;

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Scan sequencer: the counter times the current phase and freezes with ena low.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_last = (state_q == GAP0 || state_q == GAP1) ? (cnt_q == GAP_LAST)
                                                          : (cnt_q == SHOW_LAST);
        if (ena) begin
            if (phase_last) begin
                cnt_d = '0;
                case (state_q)
                    GAP0:    state_d = SHOW1;
                    SHOW1:   state_d = GAP1;
                    GAP1:    state_d = SHOW10;
                    default: state_d = GAP0;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign boundary = ena && (state_q == SHOW10) && phase_last;

    // A load on the boundary cycle bypasses the shadow and is displayed at once.
    always_comb begin
        shadow1_d  = shadow1_q;
        shadow10_d = shadow10_q;
        disp1_d    = disp1_q;
        disp10_d   = disp10_q;
        pending_d  = pending_q;
        ack_d      = 1'b0;
        if (load) begin
            shadow1_d  = digit1;
            shadow10_d = digit10;
        end
        if (boundary && (pending_q || load)) begin
            disp1_d   = load ? digit1  : shadow1_q;
            disp10_d  = load ? digit10 : shadow10_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        lit     = 7'h00;
        com_lit = 2'b00;
        if (ena) begin
            case (state_q)
                SHOW1: begin
                    lit     = encode(disp1_q);
                    com_lit = 2'b01;
                end
                SHOW10: begin
                    lit     = (blank_lz && disp10_q == 4'd0) ? 7'h00 : encode(disp10_q);
                    com_lit = 2'b10;
                end
                default: ;
            endcase
        end
        seg_d    = seg_active_high ? {1'b0, lit} : ~{1'b0, lit};
        com_d    = com_active_high ? com_lit : ~com_lit;
        com_oe_d = {ena, ena};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= GAP0;
            cnt_q      <= '0;
            shadow1_q  <= 4'hF;
            shadow10_q <= 4'hF;
            disp1_q    <= 4'hF;
            disp10_q   <= 4'hF;
            pending_q  <= 1'b0;
            ack_q      <= 1'b0;
            seg_q      <= seg_active_high ? 8'h00 : 8'hFF;
            com_q      <= com_active_high ? 2'b00 : 2'b11;
            com_oe_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow1_q  <= shadow1_d;
            shadow10_q <= shadow10_d;
            disp1_q    <= disp1_d;
            disp10_q   <= disp10_d;
            pending_q  <= pending_d;
            ack_q      <= ack_d;
            seg_q      <= seg_d;
            com_q      <= com_d;
            com_oe_q   <= com_oe_d;
        end
    end

    assign ack    = ack_q;
    assign seg    = seg_q;
    assign com    = com_q;
    assign com_oe = com_oe_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver with G=2, D=4 (12-cycle frame); cyc is
// the index of the next rising edge, so values seen at the negedge belong to cycle cyc.
module tb_seg7_mux_driver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] digit1;
    logic [3:0] digit10;
    logic       load;
    logic       ack;
    logic       seg_active_high;
    logic       com_active_high;
    logic       blank_lz;
    logic [7:0] seg;
    logic [1:0] com;
    logic [1:0] com_oe;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    seg7_mux_driver #(.REFRESH_DIV(4), .GAP_CYCLES(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .digit1          (digit1),
        .digit10         (digit10),
        .load            (load),
        .ack             (ack),
        .seg_active_high (seg_active_high),
        .com_active_high (com_active_high),
        .blank_lz        (blank_lz),
        .seg             (seg),
        .com             (com),
        .com_oe          (com_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_load(input logic [3:0] d1, input logic [3:0] d10);
        digit1  = d1;
        digit10 = d10;
        load    = 1'b1;
        $display("cyc=%0d load ones=%0d tens=%0d", cyc, d1, d10);
        tick();
        load = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] s, input logic [1:0] c,
                           input logic [1:0] oe);
        $display("cyc=%0d %s seg=%h com=%b com_oe=%b", cyc, tag, seg, com, com_oe);
        chk({tag, ".seg"}, seg, s);
        chk({tag, ".com"}, {6'd0, com}, {6'd0, c});
        chk({tag, ".oe"}, {6'd0, com_oe}, {6'd0, oe});
    endtask

    task automatic chk_ack(input string tag, input logic exp);
        $display("cyc=%0d %s ack=%b", cyc, tag, ack);
        chk(tag, {7'd0, ack}, {7'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; digit1 = 4'd0; digit10 = 4'd0; load = 1'b0;
        seg_active_high = 1'b1; com_active_high = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 8'h00, 2'b00, 2'b00);
        chk_ack("reset_ack", 1'b0);
        rst_n = 1'b1;
        cyc   = 0;
        chk_out("c0", 8'h00, 2'b00, 2'b00);

        // Basic frame with load 3/7
        tick();
        chk_out("gap0_c1", 8'h00, 2'b00, 2'b11);
        do_load(4'd3, 4'd7);
        run_to(3);   chk_out("blank_show1", 8'h00, 2'b01, 2'b11);
        run_to(11);  chk_ack("ack_c11", 1'b0);
        tick();      chk_ack("ack_c12", 1'b1);
        tick();      chk_ack("ack_c13", 1'b0);
        run_to(15);  chk_out("ones3_first", 8'h4F, 2'b01, 2'b11);
        run_to(18);  chk_out("ones3_last", 8'h4F, 2'b01, 2'b11);
        run_to(19);  chk_out("gap1_dark", 8'h00, 2'b00, 2'b11);
        run_to(21);  chk_out("tens7_first", 8'h07, 2'b10, 2'b11);
        run_to(24);  chk_out("tens7_last", 8'h07, 2'b10, 2'b11);
        run_to(25);  chk_out("gap0_dark", 8'h00, 2'b00, 2'b11);

        // Inverted polarity with digit 8
        run_to(26);
        seg_active_high = 1'b0;
        com_active_high = 1'b0;
        do_load(4'd8, 4'd8);
        chk_out("inv_ones3", 8'hB0, 2'b10, 2'b11);
        run_to(31);  chk_out("inv_gap", 8'hFF, 2'b11, 2'b11);
        run_to(36);  chk_ack("ack_c36", 1'b1);
        run_to(39);  chk_out("inv_ones8_first", 8'h80, 2'b10, 2'b11);
        run_to(42);  chk_out("inv_ones8_last", 8'h80, 2'b10, 2'b11);
        run_to(43);  chk_out("inv_gap1", 8'hFF, 2'b11, 2'b11);
        seg_active_high = 1'b1;
        com_active_high = 1'b1;

        // Leading-zero blanking with 0/5
        run_to(44);
        do_load(4'd5, 4'd0);
        run_to(48);  chk_ack("ack_c48", 1'b1);
        run_to(51);  chk_out("ones5", 8'h6D, 2'b01, 2'b11);
        run_to(57);  chk_out("tens0_shown", 8'h3F, 2'b10, 2'b11);
        run_to(58);  blank_lz = 1'b1;
        run_to(59);  chk_out("tens0_blanked", 8'h00, 2'b10, 2'b11);

        // Back-to-back loads, then a load on the boundary cycle
        run_to(61);  do_load(4'd1, 4'd2);
        run_to(63);  do_load(4'd9, 4'd9);
        run_to(72);  chk_ack("ack_c72", 1'b1);
        tick();      chk_ack("ack_c73", 1'b0);
        run_to(75);  chk_out("ones9", 8'h6F, 2'b01, 2'b11);
        run_to(81);  chk_out("tens9", 8'h6F, 2'b10, 2'b11);
        run_to(84);  chk_ack("ack_c84_single", 1'b0);
        run_to(95);  do_load(4'd4, 4'd6);
        chk_ack("ack_boundary_load", 1'b1);
        run_to(99);  chk_out("ones4", 8'h66, 2'b01, 2'b11);
        run_to(105); chk_out("tens6", 8'h7D, 2'b10, 2'b11);

        // Enable dropped mid-SHOW1 for 10 cycles
        run_to(111); ena = 1'b0;
        run_to(112); chk_out("ena_off_first", 8'h00, 2'b00, 2'b00);
        run_to(121); chk_out("ena_off_last", 8'h00, 2'b00, 2'b00);
        ena = 1'b1;
        run_to(122); chk_out("ena_resume", 8'h66, 2'b01, 2'b11);
        do_load(4'd2, 4'd2);
        run_to(124); chk_out("ena_show1_end", 8'h66, 2'b01, 2'b11);
        run_to(125); chk_out("ena_gap1", 8'h00, 2'b00, 2'b11);

        // Reset mid-SHOW10 with a load pending
        run_to(127); chk_out("pre_reset_tens", 8'h7D, 2'b10, 2'b11);
        rst_n = 1'b0;
        tick();
        chk_out("mid_reset", 8'h00, 2'b00, 2'b00);
        chk_ack("mid_reset_ack", 1'b0);
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        run_to(3);   chk_out("post_reset_ones", 8'h00, 2'b01, 2'b11);
        run_to(9);   chk_out("post_reset_tens", 8'h00, 2'b10, 2'b11);
        run_to(12);  chk_ack("post_reset_ack", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
